// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word addresses to the MMU, buffers responses in a
// small prefetch FIFO and hands them to decode. `FETCH_STALL_CNT_EN adds a stall counter.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] mem_instr_addr,
    input  logic [31:0] mem_instr,
    input  logic        mem_wait,
    input  logic        mem_segv,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_fault
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } entry_t;

    state_t        state, state_nxt;
    logic [31:0]   pc, pc_nxt;
    logic          issue;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic          inflight_fault;

    entry_t        fifo [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
    logic [CW-1:0] count, cnt_nxt;
    logic [CW:0]   occ;
    logic          credit;
    logic          push, pop;
    entry_t        push_entry, head_nxt;

    assign mem_instr_addr = pc;
    assign out_valid      = (count != '0);

    // Occupancy includes the outstanding response so the FIFO can never overflow.
    assign occ    = {1'b0, count} + (CW + 1)'(inflight);
    assign credit = occ < DEPTH_C;

    // A redirect squashes the response and ignores decode's pop in the same cycle.
    assign push = inflight && !redirect_valid;
    assign pop  = out_valid && out_ready && !redirect_valid;

    always_comb begin
        push_entry       = '0;
        push_entry.instr = inflight_fault ? 32'd0 : mem_instr;
        push_entry.pc    = inflight_pc;
        push_entry.fault = inflight_fault;
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        issue     = 1'b0;
        if (redirect_valid) begin
            state_nxt = ST_FETCH;
            pc_nxt    = redirect_pc;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (!mem_wait && credit) begin
                        issue = 1'b1;
                        // A faulting address parks the PC until software redirects.
                        if (mem_segv) state_nxt = ST_FAULT;
                        else          pc_nxt    = pc + 32'd1;
                    end
                end
                ST_FAULT: ;
                default: state_nxt = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_FETCH;
            pc             <= RESET_PC;
            inflight       <= 1'b0;
            inflight_pc    <= '0;
            inflight_fault <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            inflight <= issue;
            if (issue) begin
                inflight_pc    <= pc;
                inflight_fault <= mem_segv;
            end
        end
    end

    always_comb begin
        rd_nxt  = rd_ptr + AW'(pop);
        cnt_nxt = count + CW'(push) - CW'(pop);
        // The new head may be the entry being written this very cycle.
        if (push && (rd_nxt == wr_ptr)) head_nxt = push_entry;
        else                            head_nxt = fifo[rd_nxt];
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            out_instr <= '0;
            out_pc    <= '0;
            out_fault <= 1'b0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_nxt;
            count  <= cnt_nxt;
            // Head registers keep their last value once the FIFO runs dry.
            if (cnt_nxt != '0) begin
                out_instr <= head_nxt.instr;
                out_pc    <= head_nxt.pc;
                out_fault <= head_nxt.fault;
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (redirect_valid) begin
            stall_cnt <= '0;
        end else if ((state == ST_FETCH) && (mem_wait || !credit) && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: registered MMU model, scoreboard queue of expected
// decode-side entries, immediate-assertion checks.
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic [31:0] mem_instr_addr;
    logic [31:0] mem_instr;
    logic        mem_wait;
    logic        mem_segv;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fault;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_instr_addr (mem_instr_addr),
        .mem_instr      (mem_instr),
        .mem_wait       (mem_wait),
        .mem_segv       (mem_segv),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_fault      (out_fault)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h0100_0193) ^ 32'hC0DE_0000;
    endfunction

    // MMU model: registered data one cycle after the address, segv only at word 144.
    always @(posedge clk) mem_instr <= word(mem_instr_addr);
    assign mem_segv = (mem_instr_addr == 32'd144);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] a);
        exp_t e;
        e.instr = word(a);
        e.pc    = a;
        e.fault = 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic expect_fault(input logic [31:0] a);
        exp_t e;
        e.instr = 32'd0;
        e.pc    = a;
        e.fault = 1'b1;
        sb_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            cyc();
            n++;
        end
        check(tag, 32'(sb_q.size()), 32'd0);
    endtask

    // Scoreboard: every accepted head must match the next expected entry.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready && !redirect_valid) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL spurious_out observed pc=%0d expected none", out_pc);
            end
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_instr", out_instr, e.instr);
                check("sb_pc", out_pc, e.pc);
                check("sb_fault", 32'(out_fault), 32'(e.fault));
            end
        end
    end

    initial begin
        reset_n        = 1'b0;
        mem_wait       = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        #3;
        check("rst_addr", mem_instr_addr, 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_fault", 32'(out_fault), 32'd0);
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();

        // Streaming from reset: words 0..3, first valid two cycles after first issue.
        for (int a = 0; a < 4; a++) expect_word(32'(a));
        mem_wait = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("p1_addr", mem_instr_addr, (k < 4) ? 32'(k) : 32'd4);
            check("p1_valid", 32'(out_valid), (k >= 2) ? 32'd1 : 32'd0);
            if (k >= 2) check("p1_head_pc", out_pc, 32'(k - 2));
            cyc();
            if (k == 3) mem_wait = 1'b1;
        end
        drain("p1_drain");

        // Backpressure: exactly DEPTH issues, then the address holds.
        out_ready = 1'b0;
        mem_wait  = 1'b0;
        for (int a = 4; a < 8; a++) expect_word(32'(a));
        repeat (8) cyc();
        @(negedge clk);
        check("p2_addr_hold", mem_instr_addr, 32'd8);
        check("p2_valid", 32'(out_valid), 32'd1);
        check("p2_head_pc", out_pc, 32'd4);
        cyc();
        out_ready = 1'b1;
        mem_wait  = 1'b1;
        drain("p2_drain");

        // MMU wait for three cycles at pc 8, then two issues.
        redirect_valid = 1'b1;
        redirect_pc    = 32'd8;
        cyc();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("p3_addr_stable", mem_instr_addr, 32'd8);
            check("p3_no_push", 32'(out_valid), 32'd0);
            cyc();
        end
        mem_wait = 1'b0;
        expect_word(32'd8);
        expect_word(32'd9);
`ifdef FETCH_STALL_CNT_EN
        @(negedge clk);
        check("p3_stall_cnt", stall_cnt, 32'd3);
`endif
        cyc();
        cyc();
        mem_wait = 1'b1;
        drain("p3_drain");

        // Segv at 144: not recorded while waiting, one marker once issued, then parked.
        redirect_valid = 1'b1;
        redirect_pc    = 32'd143;
        cyc();
        redirect_valid = 1'b0;
        mem_wait       = 1'b0;
        expect_word(32'd143);
        expect_fault(32'd144);
        cyc();
        mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("p4_wait_addr", mem_instr_addr, 32'd144);
            cyc();
        end
        mem_wait = 1'b0;
        repeat (8) cyc();
        drain("p4_drain");
        @(negedge clk);
        check("p4_parked_addr", mem_instr_addr, 32'd144);
        check("p4_empty", 32'(out_valid), 32'd0);
        check("p4_hold_fault", 32'(out_fault), 32'd1);
        check("p4_hold_pc", out_pc, 32'd144);
        check("p4_hold_instr", out_instr, 32'd0);
        cyc();

        // Redirect with three buffered entries and one in flight.
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd40;
        cyc();
        redirect_valid = 1'b0;
        repeat (4) cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'd20;
        out_ready      = 1'b1;
        @(negedge clk);
        check("p5_pre_addr", mem_instr_addr, 32'd44);
        check("p5_pre_valid", 32'(out_valid), 32'd1);
        check("p5_pre_head", out_pc, 32'd40);
        cyc();
        redirect_valid = 1'b0;
        expect_word(32'd20);
        expect_word(32'd21);
        @(negedge clk);
        check("p5_flushed", 32'(out_valid), 32'd0);
        check("p5_addr", mem_instr_addr, 32'd20);
        cyc();
        @(negedge clk);
        check("p5_addr_next", mem_instr_addr, 32'd21);
        cyc();
        mem_wait = 1'b1;
        drain("p5_drain");

        // Asynchronous reset with a non-empty FIFO.
        out_ready = 1'b0;
        mem_wait  = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        check("p6_pre_valid", 32'(out_valid), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("p6_rst_valid", 32'(out_valid), 32'd0);
        check("p6_rst_addr", mem_instr_addr, 32'd0);
        check("p6_rst_pc", out_pc, 32'd0);
        mem_wait = 1'b1;
        cyc();
        cyc();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        mem_wait  = 1'b0;
        expect_word(32'd0);
        expect_word(32'd1);
        @(negedge clk);
        check("p6_restart_addr", mem_instr_addr, 32'd0);
        cyc();
        cyc();
        mem_wait = 1'b1;
        drain("p6_drain");
        repeat (4) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
